// File: rtl/fp_mul_pipe.sv
// Pipelined multi-lane floating-point multiplier with valid/ready handshakes on both sides.
// Define FPMUL_EXC_FLAGS_EN to add the per-lane {invalid,overflow,underflow} exc output.
module fp_mul_pipe #(
  parameter int  LANES = 1,
  parameter int  EXP_W = 8,
  parameter int  MAN_W = 23,
  parameter int  LAT   = 3,
  localparam int W     = 1 + EXP_W + MAN_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [LANES*W-1:0] a,
  input  logic [LANES*W-1:0] b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [LANES*W-1:0] q
`ifdef FPMUL_EXC_FLAGS_EN
  ,
  output logic [LANES*3-1:0] exc
`endif
);

  localparam int PW = 2 * MAN_W + 2;
  localparam int EW = EXP_W + 2;
  localparam logic signed [EW-1:0] BIAS   = EW'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [EW-1:0] E_MAX  = EW'((1 << EXP_W) - 1);
  localparam logic signed [EW-1:0] E_ZERO = '0;

  typedef enum logic [1:0] {K_NORM, K_ZERO, K_INF, K_NAN} kind_e;

  if (LAT < 3) begin : g_bad_lat
    $error("fp_mul_pipe: LAT must be at least 3");
  end

  // First match wins: NaN or 0 x inf, then inf, then zero. Denormals count as zero.
  function automatic kind_e classify(input logic [W-1:0] x, input logic [W-1:0] y);
    logic x_max, y_max, x_zero, y_zero, x_frac, y_frac;
    x_max  = &x[MAN_W +: EXP_W];
    y_max  = &y[MAN_W +: EXP_W];
    x_zero = ~|x[MAN_W +: EXP_W];
    y_zero = ~|y[MAN_W +: EXP_W];
    x_frac = |x[MAN_W-1:0];
    y_frac = |y[MAN_W-1:0];
    if ((x_max & x_frac) | (y_max & y_frac) | (x_zero & y_max) | (x_max & y_zero))
      return K_NAN;
    else if (x_max | y_max)
      return K_INF;
    else if (x_zero | y_zero)
      return K_ZERO;
    return K_NORM;
  endfunction

  logic           ready_q;
  logic [LAT-1:0] vld_q;
  logic           stall;
  logic           adv;
  logic           accept;

  assign stall     = vld_q[LAT-1] & ~out_ready;
  assign adv       = ~stall;
  assign in_ready  = ready_q & ~stall;
  assign accept    = in_valid & in_ready;
  assign out_valid = vld_q[LAT-1];

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q <= 1'b0;
      vld_q   <= '0;
    end else begin
      ready_q <= 1'b1;
      if (adv) vld_q <= {vld_q[LAT-2:0], accept};
    end
  end

  logic [LANES*W-1:0] s3_res;
`ifdef FPMUL_EXC_FLAGS_EN
  logic [LANES*3-1:0] s3_exc;
`endif

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [W-1:0]            op_a, op_b;
    kind_e                   s1_kind_q, s2_kind_q;
    logic                    s1_sign_q, s2_sign_q;
    logic [EXP_W-1:0]        s1_ea_q, s1_eb_q;
    logic [MAN_W:0]          s1_ma_q, s1_mb_q;
    logic [PW-1:0]           s2_prod_q;
    logic signed [EW-1:0]    s2_exp_q;
    logic                    norm_hi, guard, sticky, rnd_up;
    logic [MAN_W:0]          mant;
    logic [MAN_W+1:0]        rnd;
    logic signed [EW-1:0]    exp_n, exp_r;
    logic [MAN_W-1:0]        frac;
    logic                    is_ovf, is_unf;
    logic [W-1:0]            lane_res;

    assign op_a = a[l*W +: W];
    assign op_b = b[l*W +: W];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s1_kind_q <= K_NORM;
        s1_sign_q <= 1'b0;
        s1_ea_q   <= '0;
        s1_eb_q   <= '0;
        s1_ma_q   <= '0;
        s1_mb_q   <= '0;
        s2_kind_q <= K_NORM;
        s2_sign_q <= 1'b0;
        s2_prod_q <= '0;
        s2_exp_q  <= '0;
      end else if (adv) begin
        s1_kind_q <= classify(op_a, op_b);
        s1_sign_q <= op_a[W-1] ^ op_b[W-1];
        s1_ea_q   <= op_a[MAN_W +: EXP_W];
        s1_eb_q   <= op_b[MAN_W +: EXP_W];
        s1_ma_q   <= {1'b1, op_a[MAN_W-1:0]};
        s1_mb_q   <= {1'b1, op_b[MAN_W-1:0]};
        s2_kind_q <= s1_kind_q;
        s2_sign_q <= s1_sign_q;
        s2_prod_q <= s1_ma_q * s1_mb_q;
        s2_exp_q  <= $signed({2'b00, s1_ea_q}) + $signed({2'b00, s1_eb_q}) - BIAS;
      end
    end

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
      norm_hi  = s2_prod_q[PW-1];
      mant     = norm_hi ? s2_prod_q[PW-1 -: MAN_W+1] : s2_prod_q[PW-2 -: MAN_W+1];
      guard    = norm_hi ? s2_prod_q[MAN_W] : s2_prod_q[MAN_W-1];
      sticky   = norm_hi ? |s2_prod_q[MAN_W-1:0] : |s2_prod_q[MAN_W-2:0];
      exp_n    = s2_exp_q + $signed({{(EW-1){1'b0}}, norm_hi});
      rnd_up   = guard & (sticky | mant[0]);
      rnd      = {1'b0, mant} + {{(MAN_W+1){1'b0}}, rnd_up};
      // A rounding carry-out leaves 10...0, so the renormalised fraction is all zeros.
      exp_r    = exp_n + $signed({{(EW-1){1'b0}}, rnd[MAN_W+1]});
      frac     = rnd[MAN_W+1] ? rnd[MAN_W:1] : rnd[MAN_W-1:0];
      is_ovf   = (s2_kind_q == K_NORM) && (exp_r >= E_MAX);
      is_unf   = (s2_kind_q == K_NORM) && (exp_r <= E_ZERO);
      lane_res = {s2_sign_q, exp_r[EXP_W-1:0], frac};
      if (s2_kind_q == K_NAN)
        lane_res = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
      else if ((s2_kind_q == K_INF) || is_ovf)
        lane_res = {s2_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      else if ((s2_kind_q == K_ZERO) || is_unf)
        lane_res = {s2_sign_q, {(W-1){1'b0}}};
    end

    assign s3_res[l*W +: W] = lane_res;
`ifdef FPMUL_EXC_FLAGS_EN
    assign s3_exc[l*3 +: 3] = {s2_kind_q == K_NAN, is_ovf, is_unf};
`endif
  end

  logic [LANES*W-1:0] res_q [LAT-2];

  // NOTE: result registers are reset too, because q must read zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LAT - 2; i++) res_q[i] <= '0;
    end else if (adv) begin
      res_q[0] <= s3_res;
      for (int i = 1; i < LAT - 2; i++) res_q[i] <= res_q[i-1];
    end
  end

  assign q = res_q[LAT-3];

`ifdef FPMUL_EXC_FLAGS_EN
  logic [LANES*3-1:0] exc_q [LAT-2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LAT - 2; i++) exc_q[i] <= '0;
    end else if (adv) begin
      exc_q[0] <= s3_exc;
      for (int i = 1; i < LAT - 2; i++) exc_q[i] <= exc_q[i-1];
    end
  end

  assign exc = exc_q[LAT-3];
`endif

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Self-checking bench for fp_mul_pipe: scoreboard on a single-lane LAT=3 instance plus a
// directed check of a four-lane LAT=5 instance. Flag checks compile in with FPMUL_EXC_FLAGS_EN.
module tb_fp_mul_pipe;

  logic clk = 1'b1;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] a, b, q;
  logic         in_valid4, in_ready4, out_valid4, out_ready4;
  logic [127:0] a4, b4, q4;
`ifdef FPMUL_EXC_FLAGS_EN
  logic [2:0]  exc;
  logic [11:0] exc4;
`endif

  fp_mul_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .q(q)
`ifdef FPMUL_EXC_FLAGS_EN
    , .exc(exc)
`endif
  );

  fp_mul_pipe #(.LANES(4), .LAT(5)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
    .a(a4), .b(b4), .out_valid(out_valid4), .out_ready(out_ready4), .q(q4)
`ifdef FPMUL_EXC_FLAGS_EN
    , .exc(exc4)
`endif
  );

  typedef struct {
    logic [31:0] q;
    logic [2:0]  f;
    int          cyc;
    bit          lat;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; leaves in_valid high so calls can be chained back to back.
  task automatic send(input logic [31:0] aa, input logic [31:0] bb,
                      input logic [31:0] eq, input logic [2:0] ef, input bit lat);
    int w = 0;
    a = aa;
    b = bb;
    in_valid = 1'b1;
    #1;
    while (!in_ready && w < 20) begin
      @(negedge clk);
      #1;
      w++;
    end
    if (!in_ready) check("in_ready_timeout", in_ready, 1'b1);
    else sb.push_back('{q: eq, f: ef, cyc: cyc, lat: lat});
    @(negedge clk);
  endtask

  always begin
    @(negedge clk);
    #2;
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("spurious_out_valid", out_valid, 1'b0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("q", q, e.q);
        if (e.lat) check("latency", cyc - e.cyc, 3);
`ifdef FPMUL_EXC_FLAGS_EN
        check("exc", exc, e.f);
`endif
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int w;
    logic [31:0] exp4 [4];
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    a = '0;
    b = '0;
    in_valid4 = 1'b0;
    out_ready4 = 1'b1;
    a4 = '0;
    b4 = '0;

    #20;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_q", q, 32'h0);
    #15 rst_n = 1'b1;
    #6;
    check("in_ready_after_rst", in_ready, 1'b1);
    @(negedge clk);

    send(32'h3F800000, 32'h3F800000, 32'h3F800000, 3'b000, 1'b1);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);

    send(32'h40000000, 32'h41400000, 32'h41C00000, 3'b000, 1'b1);
    send(32'h40800000, 32'h40A00000, 32'h41A00000, 3'b000, 1'b1);
    send(32'h40A00000, 32'h40C00000, 32'h41F00000, 3'b000, 1'b1);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);

    send(32'h00000000, 32'h7F800000, 32'h7FC00000, 3'b100, 1'b1);
    send(32'h7F000000, 32'h40000000, 32'h7F800000, 3'b010, 1'b1);
    send(32'h00800000, 32'h00800000, 32'h00000000, 3'b001, 1'b1);
    send(32'h80000000, 32'h3F800000, 32'h80000000, 3'b000, 1'b1);
    send(32'h7F800000, 32'hC0000000, 32'hFF800000, 3'b000, 1'b1);
    send(32'hFFC00000, 32'h3F800000, 32'h7FC00000, 3'b100, 1'b1);
    send(32'h00000001, 32'h40000000, 32'h00000000, 3'b000, 1'b1);
    send(32'h80400000, 32'h3F800000, 32'h80000000, 3'b000, 1'b1);
    send(32'h3F800001, 32'h3FC00000, 32'h3FC00002, 3'b000, 1'b1);
    send(32'h3F800003, 32'h3FC00000, 32'h3FC00004, 3'b000, 1'b1);
    send(32'h3F800001, 32'h3FFFFFFE, 32'h40000000, 3'b000, 1'b1);
    send(32'hC0000000, 32'hC0000000, 32'h40800000, 3'b000, 1'b1);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);

    send(32'h3F800000, 32'h40000000, 32'h40000000, 3'b000, 1'b0);
    send(32'h40400000, 32'h40400000, 32'h41100000, 3'b000, 1'b0);
    send(32'hC0000000, 32'h40400000, 32'hC0C00000, 3'b000, 1'b0);
    out_ready = 1'b0;
    a = 32'h3FC00000;
    b = 32'h3FC00000;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("stall_in_ready", in_ready, 1'b0);
      check("stall_out_valid", out_valid, 1'b1);
      check("stall_q_held", q, 32'h40000000);
      @(negedge clk);
    end
    out_ready = 1'b1;
    send(32'h3FC00000, 32'h3FC00000, 32'h40100000, 3'b000, 1'b0);
    in_valid = 1'b0;

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    check("drain", sb.size(), 0);

    send(32'h40000000, 32'h40000000, 32'h40800000, 3'b000, 1'b0);
    send(32'h40400000, 32'h40000000, 32'h40C00000, 3'b000, 1'b0);
    in_valid = 1'b0;
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_q", q, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1;
      check("post_rst_out_valid", out_valid, 1'b0);
    end
    check("post_rst_in_ready", in_ready, 1'b1);

    @(negedge clk);
    a4 = {32'h40A00000, 32'h40400000, 32'h7FC00000, 32'h3F800000};
    b4 = {32'h40A00000, 32'hC0000000, 32'h3F800000, 32'h40000000};
    exp4[0] = 32'h40000000;
    exp4[1] = 32'h7FC00000;
    exp4[2] = 32'hC0C00000;
    exp4[3] = 32'h41C80000;
    in_valid4 = 1'b1;
    #1;
    w = 0;
    while (!in_ready4 && w < 20) begin
      @(negedge clk);
      #1;
      w++;
    end
    check("lanes_in_ready", in_ready4, 1'b1);
    t0 = cyc;
    @(negedge clk);
    in_valid4 = 1'b0;
    #1;
    w = 0;
    while (!out_valid4 && w < 20) begin
      @(negedge clk);
      #1;
      w++;
    end
    check("lanes_out_valid", out_valid4, 1'b1);
    check("lanes_latency", cyc - t0, 5);
    for (int l = 0; l < 4; l++) begin
      check($sformatf("lane%0d_q", l), q4[l*32 +: 32], exp4[l]);
    end
`ifdef FPMUL_EXC_FLAGS_EN
    check("lanes_exc", exc4, 12'b000_000_100_000);
`endif
    @(negedge clk);
    #1;
    check("lanes_single_result", out_valid4, 1'b0);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
